// File: rtl/seq_detect_mealy.sv
// Mealy detector for a runtime-loadable LEN-bit pattern with overlap control
// and a saturating match counter.
module seq_detect_mealy #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter int             CNT_W   = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             en_i,
  input  logic             in_i,
  input  logic             overlap_i,
  input  logic             load_i,
  input  logic [LEN-1:0]   pattern_i,
  input  logic             clear_i,
  output logic             match_o,
  output logic [CNT_W-1:0] count_o,
  output logic             sat_o
);

  localparam int               FW       = $clog2(LEN);
  localparam logic [FW-1:0]    FILL_MAX = FW'(LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    ARMED   = 2'd2
  } phase_t;

  logic [LEN-1:0]   r_pattern;
  logic [LEN-2:0]   r_hist;
  logic [FW-1:0]    r_fill;
  logic [CNT_W-1:0] r_cnt;

  logic [LEN-1:0]   w_window;
  logic             w_accept;
  logic             w_match;
  phase_t           w_phase;

  always_comb begin
    w_phase = FILLING;
    if (r_fill == '0)
      w_phase = EMPTY;
    else if (r_fill == FILL_MAX)
      w_phase = ARMED;
  end

  // Window is the stored history with the incoming bit as its newest bit.
  assign w_window = {r_hist, in_i};
  assign w_accept = en_i & ~load_i;
  assign w_match  = w_accept & (w_phase == ARMED) & (w_window == r_pattern);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_pattern <= PATTERN;
      r_hist    <= '0;
      r_fill    <= '0;
      r_cnt     <= '0;
    end else begin
      if (load_i) begin
        r_pattern <= pattern_i;
        r_hist    <= '0;
        r_fill    <= '0;
      end else if (en_i) begin
        r_hist <= w_window[LEN-2:0];
        if (w_match && !overlap_i)
          r_fill <= '0;
        else if (w_phase != ARMED)
          r_fill <= r_fill + 1'b1;
      end

      // Clear wins over a same-cycle match.
      if (clear_i)
        r_cnt <= '0;
      else if (w_match && (r_cnt != CNT_MAX))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign match_o = w_match;
  assign count_o = r_cnt;
  assign sat_o   = (r_cnt == CNT_MAX);

endmodule

// File: tb/tb_seq_detect_mealy.sv
// Directed bench for seq_detect_mealy; a queue-based model of the accepted
// bit stream is compared against the DUT every cycle.
module tb_seq_detect_mealy;

  localparam int LEN   = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = 3;

  logic             clk_i     = 1'b0;
  logic             reset_ni  = 1'b0;
  logic             en_i      = 1'b0;
  logic             in_i      = 1'b0;
  logic             overlap_i = 1'b0;
  logic             load_i    = 1'b0;
  logic [LEN-1:0]   pattern_i = '0;
  logic             clear_i   = 1'b0;
  logic             match_o;
  logic [CNT_W-1:0] count_o;
  logic             sat_o;

  seq_detect_mealy #(.LEN(LEN), .PATTERN(4'b1011), .CNT_W(CNT_W)) dut (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .en_i      (en_i),
    .in_i      (in_i),
    .overlap_i (overlap_i),
    .load_i    (load_i),
    .pattern_i (pattern_i),
    .clear_i   (clear_i),
    .match_o   (match_o),
    .count_o   (count_o),
    .sat_o     (sat_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Model: accepted bits since the last flush (newest at the back).
  bit             q[$];
  int             cnt_m;
  logic [LEN-1:0] pat_m;
  logic           m_seen;
  logic [CNT_W-1:0] cnt_seen;
  int             txn = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_match(input bit en, input bit b, input bit ld);
    if (!en || ld || q.size() < LEN - 1) return 1'b0;
    for (int i = 0; i < LEN - 1; i++)
      if (q[q.size() - (LEN - 1) + i] != pat_m[LEN-1-i]) return 1'b0;
    return b == pat_m[0];
  endfunction

  task automatic model_reset();
    q.delete();
    cnt_m = 0;
    pat_m = 4'b1011;
  endtask

  task automatic cyc(input bit en, input bit b, input bit ov = 1'b1, input bit ld = 1'b0,
                     input logic [LEN-1:0] pat = '0, input bit clr = 1'b0);
    bit exp_m;
    @(negedge clk_i);
    en_i = en; in_i = b; overlap_i = ov; load_i = ld; pattern_i = pat; clear_i = clr;
    #1;
    exp_m = model_match(en, b, ld);
    chk("match_o", match_o, exp_m);
    chk("count_o", count_o, cnt_m);
    chk("sat_o", sat_o, (cnt_m == CMAX));
    m_seen   = match_o;
    cnt_seen = count_o;
    txn++;
    $display("txn %0d en=%0b in=%0b ov=%0b ld=%0b clr=%0b match=%0b count=%0d sat=%0b",
             txn, en, b, ov, ld, clr, match_o, count_o, sat_o);
    if (ld) begin
      pat_m = pat;
      q.delete();
    end else if (en) begin
      q.push_back(b);
      if (exp_m && !ov) q.delete();
      while (q.size() > LEN - 1) void'(q.pop_front());
    end
    if (clr) cnt_m = 0;
    else if (exp_m && cnt_m < CMAX) cnt_m++;
  endtask

  task automatic feed(input logic [LEN-1:0] bits, input bit ov);
    for (int i = LEN - 1; i >= 0; i--) cyc(1'b1, bits[i], ov);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #3;
    chk("reset_match", match_o, 1'b0);
    chk("reset_count", count_o, 0);
    chk("reset_sat", sat_o, 1'b0);
    #9 reset_ni = 1'b1;

    // Overlapping: 1,0,1,1,0,1,1 matches on samples 4 and 7
    feed(4'b1011, 1'b1);
    chk("ov_s4", m_seen, 1'b1);
    cyc(1'b1, 1'b0);
    chk("ov_cnt_after4", cnt_seen, 1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    chk("ov_s7", m_seen, 1'b1);
    cyc(1'b0, 1'b0);
    chk("ov_cnt_after7", cnt_seen, 2);

    // Non-overlapping: same stream, only sample 4 matches
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'b1011, 1'b1);
    feed(4'b1011, 1'b0);
    chk("nov_s4", m_seen, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("nov_s7", m_seen, 1'b0);
    cyc(1'b0, 1'b0);
    chk("nov_cnt", cnt_seen, 1);

    // Enable gating with garbage on disabled cycles
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'b1011, 1'b1);
    cyc(1'b1, 1'b1); cyc(1'b0, 1'b1); cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1); cyc(1'b0, 1'b0); cyc(1'b0, 1'b1);
    chk("gate_disabled", m_seen, 1'b0);
    cyc(1'b1, 1'b1);
    chk("gate_match", m_seen, 1'b1);
    cyc(1'b0, 1'b0);
    chk("gate_cnt", cnt_seen, 1);

    // Saturation with pattern 1111 and continuous ones
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    chk("sat_cnt", cnt_seen, CMAX);
    chk("sat_flag", sat_o, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    chk("clr_match", m_seen, 1'b1);
    cyc(1'b0, 1'b0);
    chk("clr_cnt", cnt_seen, 0);
    chk("clr_sat", sat_o, 1'b0);

    // Runtime load while armed with matching history
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'b1011, 1'b1);
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b0); cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'b0110);
    chk("load_blocks", m_seen, 1'b0);
    feed(4'b0110, 1'b1);
    chk("load_new_pat", m_seen, 1'b1);
    feed(4'b1011, 1'b1);
    chk("load_old_pat", m_seen, 1'b0);

    // Asynchronous reset mid-stream
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'b1011, 1'b0);
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b0); cyc(1'b1, 1'b1);
    @(negedge clk_i);
    en_i = 1'b1; in_i = 1'b1; load_i = 1'b0; clear_i = 1'b0; overlap_i = 1'b1;
    #1;
    chk("pre_rst_match", match_o, 1'b1);
    chk("pre_rst_count", count_o, cnt_m);
    #1 reset_ni = 1'b0;
    #1;
    chk("rst_match", match_o, 1'b0);
    chk("rst_count", count_o, 0);
    chk("rst_sat", sat_o, 1'b0);
    @(negedge clk_i);
    en_i = 1'b0;
    #1 reset_ni = 1'b1;
    model_reset();
    cyc(1'b1, 1'b1);
    chk("post_rst_single", m_seen, 1'b0);
    feed(4'b1011, 1'b1);
    chk("post_rst_full", m_seen, 1'b1);
    cyc(1'b0, 1'b0);
    chk("post_rst_cnt", cnt_seen, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
